// File: rtl/output_drainer_pkg.sv
// ---------------------------------------------------------------------------
// output_drainer_pkg
// Shared constants for the output-side filler/drainer pair: word width, block
// geometry, index width and the two-state drain FSM encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package output_drainer_pkg;

    localparam int WORD_W    = 64;                 // bits per emitted word
    localparam int NUM_WORDS = 40;                 // words per captured block
    localparam int IDX_W     = 6;                  // 2**IDX_W >= NUM_WORDS
    localparam int BLOCK_W   = WORD_W * NUM_WORDS; // 2560-bit block

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // Drain FSM encoding, kept as plain constants for legacy tools.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/output_drainer_if.sv
// ---------------------------------------------------------------------------
// output_drainer_if
// Bundles the block-load handshake and the outgoing word stream.
//   load_L / in / load_ready            : block load (active-low strobe)
//   out / out_valid / out_ready         : valid/ready word stream
//   word_idx / last / done              : stream position and completion
// Modports: master = the drainer, slave = the surrounding logic.
// ---------------------------------------------------------------------------
interface output_drainer_if;
    import output_drainer_pkg::*;

    logic               load_L;
    logic [BLOCK_W-1:0] in;
    logic               load_ready;
    logic [WORD_W-1:0]  out;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   word_idx;
    logic               last;
    logic               done;

    modport master (
        input  load_L, in, out_ready,
        output load_ready, out, out_valid, word_idx, last, done
    );

    modport slave (
        output load_L, in, out_ready,
        input  load_ready, out, out_valid, word_idx, last, done
    );

endinterface

// File: rtl/output_drainer_word_mux.sv
// ---------------------------------------------------------------------------
// output_drainer_word_mux
// Combinational NUM_WORDS:1 word selector. Word k is the k-th most
// significant WORD_W slice of the block, so word 0 is the top word.
//   block_i : block to select from
//   sel_i   : word index; values >= NUM_WORDS return zero
//   word_o  : selected word
// ---------------------------------------------------------------------------
module output_drainer_word_mux
    import output_drainer_pkg::*;
(
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [IDX_W-1:0]   sel_i,
    output logic [WORD_W-1:0]  word_o
);

    // NOTE: combinational logic uses blocking assignments so later statements
    // see the values written by earlier ones within the same evaluation.
    always_comb begin
        word_o = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (sel_i == IDX_W'(k)) begin
                word_o = block_i[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/output_drainer.sv
// ---------------------------------------------------------------------------
// output_drainer
// Captures a finished 40-word block in one cycle and streams it out one
// 64-bit word per beat, most significant word first, so a filler followed by
// this drainer returns words in their original arrival order.
//   clock   : single clock, posedge
//   reset_L : asynchronous active-low reset
//   dif     : output_drainer_if.master (load handshake + word stream)
// All stream outputs are registered; only load_ready is combinational.
// ---------------------------------------------------------------------------
module output_drainer
    import output_drainer_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_L,
    output_drainer_if.master      dif
);

    logic [0:0]         state_q, state_d;
    logic [BLOCK_W-1:0] buf_q,   buf_d;
    logic [WORD_W-1:0]  out_q,   out_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               last_q,  last_d;
    logic               done_q,  done_d;

    logic               beat;
    logic               load_acc;
    logic               idx_clr;
    logic               idx_en;
    logic [BLOCK_W-1:0] mux_block;
    logic [IDX_W-1:0]   mux_sel;
    logic [WORD_W-1:0]  mux_word;

    assign beat           = valid_q && dif.out_ready;
    assign dif.load_ready = (state_q == ST_IDLE) ||
                            (state_q == ST_DRAIN && last_q && dif.out_ready);
    assign load_acc       = !dif.load_L && dif.load_ready;

    // One selector serves both cases: on a load it picks word 0 of the
    // incoming block (the buffer is not written yet), otherwise the next
    // buffered word. The out-of-range select after the last word is never used.
    assign mux_block = load_acc ? dif.in : buf_q;
    assign mux_sel   = load_acc ? '0 : idx_q + IDX_W'(1);

    output_drainer_word_mux u_word_mux (
        .block_i (mux_block),
        .sel_i   (mux_sel),
        .word_o  (mux_word)
    );

    // Enable counter with synchronous clear: clear on any load or when the
    // final word leaves, step on every other beat.
    assign idx_clr = load_acc || (beat && last_q);
    assign idx_en  = beat && !last_q;

    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        out_d   = out_q;
        valid_d = valid_q;
        done_d  = beat && last_q;

        if (load_acc) begin
            state_d = ST_DRAIN;
            buf_d   = dif.in;
            out_d   = mux_word;
            valid_d = 1'b1;
        end else if (beat) begin
            if (last_q) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end else begin
                out_d = mux_word;
            end
        end

        if (idx_clr) begin
            idx_d = '0;
        end else if (idx_en) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end

        last_d = valid_d && (idx_d == LAST_IDX);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values. The block buffer is reset along with the rest
    // so a block discarded by reset can never resurface on the stream.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign dif.out       = out_q;
    assign dif.out_valid = valid_q;
    assign dif.word_idx  = idx_q;
    assign dif.last      = last_q;
    assign dif.done      = done_q;

endmodule

// File: tb/tb_output_drainer.sv
// ---------------------------------------------------------------------------
// tb_output_drainer
// Self-checking bench for output_drainer. Blocks are built from an ordered
// list of words (first word placed most significant); the stream is expected
// to replay that list in order, one word per beat, holding steady on stalls.
// ---------------------------------------------------------------------------
module tb_output_drainer;
    import output_drainer_pkg::*;

    typedef logic [WORD_W-1:0] words_t [NUM_WORDS];

    logic clock   = 1'b0;
    logic reset_L = 1'b0;

    int tests = 0;
    int fails = 0;

    output_drainer_if dif ();

    output_drainer dut (
        .clock   (clock),
        .reset_L (reset_L),
        .dif     (dif)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Arrival order -> block: first word ends up in the top slice.
    function automatic logic [BLOCK_W-1:0] pack_words(input words_t w);
        logic [BLOCK_W-1:0] b = '0;
        for (int k = 0; k < NUM_WORDS; k++) b = (b << WORD_W) | BLOCK_W'(w[k]);
        return b;
    endfunction

    function automatic words_t rand_words();
        words_t w;
        for (int k = 0; k < NUM_WORDS; k++) w[k] = {$urandom, $urandom};
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] first_word(input logic [BLOCK_W-1:0] b);
        return WORD_W'(b >> (WORD_W * (NUM_WORDS - 1)));
    endfunction

    task automatic load_block(input string tag, input logic [BLOCK_W-1:0] b);
        dif.in     = b;
        dif.load_L = 1'b0;
        #1;
        tests++;
        if (dif.load_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s load: load_ready=%b out_valid=%b, required 1/0",
                     tag, dif.load_ready, dif.out_valid);
        end
        tick();
        dif.load_L = 1'b1;
        dif.in     = ~b;   // input must no longer matter
    endtask

    // Drains one block expected to be on the stream right now.
    // mode 0: ready always; 1: ready 1,0,0 repeating; 2: random ready.
    task automatic drain(input string tag, input words_t exp, input int mode,
                         input bit b2b, input logic [BLOCK_W-1:0] next_b,
                         input int busy_at, input logic [BLOCK_W-1:0] busy_b);
        int  n = 0;
        int  cyc = 0;
        bit  fin = 0;
        bit  busy_done = 0;
        logic exp_lr;
        while (!fin && cyc < 4000) begin
            dif.load_L = 1'b1;
            case (mode)
                0:       dif.out_ready = 1'b1;
                1:       dif.out_ready = (cyc % 3 == 0);
                default: dif.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (busy_at >= 0 && !busy_done && n == busy_at) begin
                dif.in     = busy_b;
                dif.load_L = 1'b0;
                busy_done  = 1;
            end
            if (b2b && n == NUM_WORDS - 1 && dif.out_ready) begin
                dif.in     = next_b;
                dif.load_L = 1'b0;
            end
            #1;
            tests++;
            if (dif.out_valid !== 1'b1 || dif.word_idx !== IDX_W'(n) || dif.out !== exp[n]) begin
                fails++;
                $display("FAIL %s word: valid=%b idx=%0d out=%h, required 1/%0d/%h",
                         tag, dif.out_valid, dif.word_idx, dif.out, n, exp[n]);
            end
            tests++;
            if (dif.last !== (n == NUM_WORDS - 1)) begin
                fails++;
                $display("FAIL %s last: got %b at word %0d", tag, dif.last, n);
            end
            if (cyc > 0) begin
                tests++;
                if (dif.done !== 1'b0) begin
                    fails++;
                    $display("FAIL %s done_early: got %b at word %0d", tag, dif.done, n);
                end
            end
            if (!dif.load_L) begin
                exp_lr = (n == NUM_WORDS - 1) && dif.out_ready;
                tests++;
                if (dif.load_ready !== exp_lr) begin
                    fails++;
                    $display("FAIL %s load_ready: got %b, required %b at word %0d",
                             tag, dif.load_ready, exp_lr, n);
                end
            end
            if (dif.out_ready) begin
                n++;
                if (n == NUM_WORDS) fin = 1;
            end
            tick();
            cyc++;
        end
        dif.load_L = 1'b1;
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: %0d of %0d words seen", tag, n, NUM_WORDS);
        end
        tests++;
        if (dif.done !== 1'b1 || dif.out_valid !== b2b) begin
            fails++;
            $display("FAIL %s done: done=%b out_valid=%b, required 1/%b",
                     tag, dif.done, dif.out_valid, b2b);
        end
        if (b2b) begin
            tests++;
            if (dif.word_idx !== '0 || dif.out !== first_word(next_b)) begin
                fails++;
                $display("FAIL %s b2b_first: idx=%0d out=%h, required 0/%h",
                         tag, dif.word_idx, dif.out, first_word(next_b));
            end
        end
        dif.out_ready = 1'b0;
        tick();
        tests++;
        if (dif.done !== 1'b0 || dif.out_valid !== b2b) begin
            fails++;
            $display("FAIL %s after: done=%b out_valid=%b, required 0/%b",
                     tag, dif.done, dif.out_valid, b2b);
        end
    endtask

    task automatic test_reset();
        reset_L       = 1'b0;
        dif.load_L    = 1'b1;
        dif.out_ready = 1'b1;
        dif.in        = {80{32'hA5A5_5A5A}};
        #12;
        tests++;
        if (dif.out_valid !== 1'b0 || dif.out !== '0 || dif.word_idx !== '0 ||
            dif.last !== 1'b0 || dif.done !== 1'b0 || dif.load_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: valid=%b out=%h idx=%0d last=%b done=%b load_ready=%b, required 0/0/0/0/0/1",
                     dif.out_valid, dif.out, dif.word_idx, dif.last, dif.done, dif.load_ready);
        end
        #1;
        reset_L = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        dif.load_L    = 1'b1;
        dif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (dif.out_valid !== 1'b0 || dif.done !== 1'b0) begin
                fails++;
                $display("FAIL idle: out_valid=%b done=%b, required 0/0", dif.out_valid, dif.done);
            end
        end
    endtask

    function automatic words_t basic_words();
        words_t w;
        for (int k = 0; k < NUM_WORDS; k++) w[k] = {8{8'(k + 1)}};
        return w;
    endfunction

    task automatic test_basic();
        words_t w = basic_words();
        load_block("basic", pack_words(w));
        drain("basic", w, 0, 0, '0, -1, '0);
    endtask

    task automatic test_backpressure();
        words_t w = basic_words();
        load_block("bp_pattern", pack_words(w));
        drain("bp_pattern", w, 1, 0, '0, -1, '0);
        load_block("bp_random", pack_words(w));
        drain("bp_random", w, 2, 0, '0, -1, '0);
    endtask

    task automatic test_back_to_back();
        words_t w1 = basic_words();
        words_t w2;
        for (int k = 0; k < NUM_WORDS; k++) w2[k] = 64'hFFFF_0000_FFFF_0000 ^ 64'(k);
        load_block("b2b", pack_words(w1));
        drain("b2b_1", w1, 0, 1, pack_words(w2), -1, '0);
        drain("b2b_2", w2, 0, 0, '0, -1, '0);
    endtask

    task automatic test_load_while_busy();
        words_t w = rand_words();
        words_t other = rand_words();
        load_block("busy", pack_words(w));
        drain("busy", w, 0, 0, '0, 10, pack_words(other));
    endtask

    task automatic test_reset_mid_drain();
        words_t w = rand_words();
        words_t w2 = rand_words();
        int c = 0;
        load_block("rst_mid", pack_words(w));
        dif.out_ready = 1'b1;
        while (dif.word_idx != IDX_W'(20) && c < 100) begin
            tick();
            c++;
        end
        tests++;
        if (c >= 100) begin
            fails++;
            $display("FAIL rst_mid timeout: word_idx=%0d, required 20", dif.word_idx);
        end
        #2;
        reset_L = 1'b0;
        #1;
        tests++;
        if (dif.out_valid !== 1'b0 || dif.out !== '0 || dif.word_idx !== '0 ||
            dif.done !== 1'b0 || dif.last !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid async: valid=%b out=%h idx=%0d done=%b last=%b, required all 0",
                     dif.out_valid, dif.out, dif.word_idx, dif.done, dif.last);
        end
        #3;
        reset_L = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (dif.out_valid !== 1'b0 || dif.done !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid idle: out_valid=%b done=%b, required 0/0",
                         dif.out_valid, dif.done);
            end
        end
        load_block("rst_mid_reload", pack_words(w2));
        drain("rst_mid_reload", w2, 0, 0, '0, -1, '0);
    endtask

    task automatic test_round_trip();
        // Words in filler arrival order; the filler places the first arrival
        // in the top slice, which pack_words reproduces.
        words_t seq = rand_words();
        load_block("round_trip", pack_words(seq));
        drain("round_trip", seq, 2, 0, '0, -1, '0);
    endtask

    task automatic test_random_chain();
        words_t cur = rand_words();
        words_t nxt;
        load_block("chain", pack_words(cur));
        for (int i = 0; i < 4; i++) begin
            nxt = rand_words();
            drain("chain", cur, 2, (i < 3), pack_words(nxt), -1, '0);
            cur = nxt;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_load_while_busy();
        test_reset_mid_drain();
        test_round_trip();
        test_random_chain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_drainer.md
Name: output_drainer

Overview:
- Parallel-to-serial converter for finished interpolated blocks; the counterpart of the output-side filler.
- Captures one 2560-bit block (8 rows x 8 cols x 5 pixels x 8 bits = 40 words of 64 bits) in one cycle.
- Emits the block as 40 sequential 64-bit words on a valid/ready stream toward the memory writer.
- Word order is filler-inverse: filler-then-drainer returns words in their original arrival order.

Parameters:
- WORD_W, 64, bits per emitted word.
- NUM_WORDS, 40, words per captured block.
- IDX_W, 6, width of word index; must satisfy 2^IDX_W >= NUM_WORDS.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- load_L  input  1  active-low block load strobe.
- in  input  WORD_W*NUM_WORDS  block to drain; sampled only when a load is accepted.
- load_ready  output  1  high when a load this cycle will be accepted.
- out  output  WORD_W  current word.
- out_valid  output  1  out holds a valid word.
- out_ready  input  1  downstream accepts out this cycle.
- word_idx  output  IDX_W  index (0..NUM_WORDS-1) of the word on out.
- last  output  1  high with out_valid when word_idx == NUM_WORDS-1.
- done  output  1  one-cycle pulse after the last word handshakes.

Behaviour:
- Reset (async, reset_L low): state=IDLE; block buffer, out, word_idx = 0; out_valid, last, done = 0. Reset mid-drain discards the block; no partial words after release.
- States: IDLE, DRAIN.
- Beat = out_valid && out_ready at posedge.
- Word k mapping: out = buffer[(NUM_WORDS-1-k)*WORD_W +: WORD_W]. Word 0 is the most significant word of in.
- load_ready is combinational: (state==IDLE) || (state==DRAIN && last && out_ready).
- IDLE:
  - out_valid=0.
  - load_L low: capture in; next cycle state=DRAIN, out_valid=1, word_idx=0, out=word 0.
  - Latency from load to first valid word: 1 cycle.
- DRAIN, beat with word_idx < NUM_WORDS-1: word_idx++; out updates to the next word on the next cycle.
- DRAIN, no beat: out, word_idx, out_valid, last held stable. Mandatory; the stream must not drop or alter a stalled word.
- DRAIN, beat on last word, load_L high: state=IDLE, out_valid=0, done=1 for exactly the next cycle.
- DRAIN, beat on last word, load_L low (back-to-back): capture new in; stay DRAIN with word_idx=0, out=new word 0, out_valid=1, done=1. No bubble cycle.
- load_L low while load_ready=0: ignored. Buffer, index and output unchanged; no error flag.
- out_ready while out_valid=0: no effect.
- Throughput: one word per cycle with out_ready held high. 40 cycles per block; back-to-back blocks sustain 100%.
- out, out_valid, last, word_idx and done are registered, with no combinational path from in or out_ready. Only load_ready is combinational.
- Indexing never wraps past NUM_WORDS-1; an index beyond that is unreachable.

Decomposition:
- Shared package constants: WORD_W, NUM_WORDS, IDX_W, block width (WORD_W*NUM_WORDS). The filler uses the same constants.
- Shared package state encoding: IDLE=0, DRAIN=1.
- One natural sub-module: drain_word_mux, a combinational NUM_WORDS:1 word selector indexed by word_idx, feeding the out register.
- Index logic uses the existing enable-counter style, with a synchronous clear on load.

Test Plan:
- Basic drain: word k of in = {8{8'(k+1)}} at position 39-k, out_ready=1, one load. Expect out_valid one cycle after load; words 0x0101..01 through 0x2828..28 in order; last high only on word 39; done pulse on cycle 41; out_valid low after.
- Backpressure: same block, out_ready toggling 1,0,0,1,… and random. Expect out/word_idx stable during every stall; exactly 40 beats; no duplicates or skips.
- Back-to-back: second block (all words 0xFFFF_0000_FFFF_0000 ^ k) with load_L low on the last-word beat. Expect word 0 of block 2 the cycle after word 39 of block 1; done pulse the same cycle; no out_valid gap.
- Load while busy: pulse load_L at word_idx=10 with a different block. Expect load_ready=0 and the original block's words 10..39 emitted unchanged.
- Reset mid-drain: assert reset_L low asynchronously at word_idx=20, between clock edges. Expect out_valid, out, word_idx, done = 0 immediately; after release, IDLE with no output until a new load.
- Round trip: feed 40 words through output_filler, load its out into this block. Expect emitted words equal to the filler input sequence in the same order.
